dec_entry_to_bin: RTL and testbench

DEC_ENTRY_TO_BIN -- requirements
Module: dec_entry_to_bin

---
 rtl/dec_entry_to_bin_pkg.sv | 28 ++
 rtl/dec_entry_to_bin_seg7_encode.sv | 14 +
 rtl/dec_entry_to_bin.sv | 148 ++++++++++++++
 tb/tb_dec_entry_to_bin.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/dec_entry_to_bin_pkg.sv
// Shared definitions for dec_entry_to_bin: FSM state encoding and the
// active-low 7-segment (a..g) pattern table used by the optional digit echo.
package dec_entry_to_bin_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [3:0] SEG_BLANK_IDX = 4'd10;

  // Entry k is the pattern for digit k, written a..g from MSB to LSB; entry 10 is blank.
  localparam logic [10:0][6:0] SEG7_TABLE = {
    7'b1111111,  // blank
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

endpackage

// File: rtl/dec_entry_to_bin_seg7_encode.sv
// Digit to active-low 7-segment pattern (index 0 = segment a); codes above 9 show blank.
// Only present when DIGIT_ECHO_EN is defined, since only the echo path uses it.
`ifdef DIGIT_ECHO_EN
module seg7_encode
  import dec_entry_to_bin_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [0:6] o_seg
);

  assign o_seg = (i_digit <= 4'd9) ? SEG7_TABLE[i_digit] : SEG7_TABLE[SEG_BLANK_IDX];

endmodule
`endif

// File: rtl/dec_entry_to_bin.sv
// Keypad-style decimal entry: accumulates BCD digits MSD first and commits a binary result
// held under a valid/ready handshake. Define DIGIT_ECHO_EN to add the seg_echo display output.
module dec_entry_to_bin
  import dec_entry_to_bin_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter int N          = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   digit_in,
  input  logic         digit_valid,
  input  logic         enter,
  input  logic         clear,
  output logic [N-1:0] result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         bad_digit,
`ifdef DIGIT_ECHO_EN
  output logic [0:6]   seg_echo,
`endif
  output logic         overflow
);

  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] MAX_COUNT = CW'(NUM_DIGITS);

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_acc, w_acc_nxt, w_mac;
  logic [CW-1:0]  r_count, w_count_nxt;
  logic [N-1:0]   r_result, w_result_nxt;
  logic           r_result_valid, w_result_valid_nxt;
  logic           r_bad_digit, w_bad_digit_nxt;
  logic           r_overflow, w_overflow_nxt;
  logic           w_entry, w_clear, w_digit_ok, w_accept, w_release;

  assign w_entry    = (r_state != ST_HOLD);
  assign w_clear    = w_entry && clear;
  assign w_digit_ok = digit_valid && (digit_in <= 4'd9);
  assign w_accept   = w_entry && !clear && w_digit_ok && (r_count < MAX_COUNT);
  assign w_release  = (r_state == ST_HOLD) && r_result_valid && result_ready;
  assign w_mac      = N'(({4'b0000, r_acc} << 3) + ({4'b0000, r_acc} << 1) + (N+4)'(digit_in));

  // Next-state and datapath decisions for the entry FSM.
  always_comb begin
    w_state_nxt        = r_state;
    w_acc_nxt          = r_acc;
    w_count_nxt        = r_count;
    w_result_nxt       = r_result;
    w_result_valid_nxt = r_result_valid;
    w_bad_digit_nxt    = 1'b0;
    w_overflow_nxt     = r_overflow;
    case (r_state)
      ST_IDLE, ST_ACCUM: begin
        if (clear) begin
          w_acc_nxt      = '0;
          w_count_nxt    = '0;
          w_overflow_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_bad_digit_nxt = digit_valid && (digit_in > 4'd9);
          if (w_digit_ok && (r_count == MAX_COUNT)) begin
            w_overflow_nxt = 1'b1;
          end else begin
            w_overflow_nxt = r_overflow;
          end
          if (w_accept) begin
            w_acc_nxt   = w_mac;
            w_count_nxt = r_count + 1'b1;
            w_state_nxt = ST_ACCUM;
          end else begin
            w_acc_nxt = r_acc;
          end
          if (enter && (w_accept || (r_state == ST_ACCUM))) begin
            w_result_nxt       = w_accept ? w_mac : r_acc;
            w_result_valid_nxt = 1'b1;
            w_state_nxt        = ST_HOLD;
          end else begin
            w_result_valid_nxt = r_result_valid;
          end
        end
      end
      ST_HOLD: begin
        if (w_release) begin
          w_acc_nxt          = '0;
          w_count_nxt        = '0;
          w_result_valid_nxt = 1'b0;
          w_overflow_nxt     = 1'b0;
          w_state_nxt        = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; rst overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_acc          <= '0;
      r_count        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_bad_digit    <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_acc          <= w_acc_nxt;
      r_count        <= w_count_nxt;
      r_result       <= w_result_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_bad_digit    <= w_bad_digit_nxt;
      r_overflow     <= w_overflow_nxt;
    end
  end

  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign bad_digit    = r_bad_digit;
  assign overflow     = r_overflow;

`ifdef DIGIT_ECHO_EN
  logic [3:0] r_echo_code;

  // Last accepted digit, blanked whenever the entry is discarded or released.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_echo_code <= SEG_BLANK_IDX;
    end else if (w_clear || w_release) begin
      r_echo_code <= SEG_BLANK_IDX;
    end else if (w_accept) begin
      r_echo_code <= digit_in;
    end else begin
      r_echo_code <= r_echo_code;
    end
  end

  seg7_encode u_seg7_encode (
    .i_digit (r_echo_code),
    .o_seg   (seg_echo)
  );
`endif

endmodule

// File: tb/tb_dec_entry_to_bin.sv
// Directed self-checking bench for dec_entry_to_bin (default NUM_DIGITS=2, N=7).
// Checks seg_echo as well when DIGIT_ECHO_EN is defined.
module tb_dec_entry_to_bin;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       result_ready = 1'b0;
  logic [6:0] result;
  logic       result_valid;
  logic       bad_digit;
  logic       overflow;
`ifdef DIGIT_ECHO_EN
  logic [0:6] seg_echo;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dec_entry_to_bin #(.NUM_DIGITS(2), .N(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .digit_in     (digit_in),
    .digit_valid  (digit_valid),
    .enter        (enter),
    .clear        (clear),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .bad_digit    (bad_digit),
`ifdef DIGIT_ECHO_EN
    .seg_echo     (seg_echo),
`endif
    .overflow     (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    digit_valid = 1'b0; enter = 1'b0; clear = 1'b0; result_ready = 1'b0; rst = 1'b0;
  endtask

  task automatic digit(input logic [3:0] d);
    digit_valid = 1'b1; digit_in = d; tick(); digit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); quiet();
    n_checks++; if (result !== 7'd0) begin n_fail++; $display("FAIL reset_result: got %0d want 0", result); end
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    n_checks++; if (bad_digit !== 1'b0) begin n_fail++; $display("FAIL reset_bad: got %b want 0", bad_digit); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_basic_42();
    digit(4'd4); digit(4'd2);
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL b42_early_valid: got %b want 0", result_valid); end
    enter = 1'b1; tick(); enter = 1'b0;
    n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL b42_valid: got %b want 1", result_valid); end
    n_checks++; if (result !== 7'd42) begin n_fail++; $display("FAIL b42_result: got %0d want 42", result); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL b42_drop: got %b want 0", result_valid); end
    n_checks++; if (result !== 7'd42) begin n_fail++; $display("FAIL b42_keep: got %0d want 42", result); end
  endtask

  task automatic test_overflow();
    digit(4'd9); digit(4'd9);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
    digit(4'd7);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow); end
    tick();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    enter = 1'b1; tick(); enter = 1'b0;
    n_checks++; if (result !== 7'd99) begin n_fail++; $display("FAIL ovf_result: got %0d want 99", result); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_release: got %b want 0", overflow); end
  endtask

  task automatic test_bad_digit();
    digit(4'd12);
    n_checks++; if (bad_digit !== 1'b1) begin n_fail++; $display("FAIL bad_pulse: got %b want 1", bad_digit); end
    tick();
    n_checks++; if (bad_digit !== 1'b0) begin n_fail++; $display("FAIL bad_clear: got %b want 0", bad_digit); end
    enter = 1'b1; tick(); enter = 1'b0;
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL bad_no_entry: got %b want 0", result_valid); end
    digit(4'd5); enter = 1'b1; tick(); enter = 1'b0;
    n_checks++; if (result !== 7'd5) begin n_fail++; $display("FAIL bad_result: got %0d want 5", result); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
  endtask

  task automatic test_digit_with_enter();
    digit(4'd3);
    digit_valid = 1'b1; digit_in = 4'd8; enter = 1'b1; tick();
    n_checks++; if (result !== 7'd38 || result_valid !== 1'b1) begin n_fail++; $display("FAIL dwe_result: got %0d/%b want 38/1", result, result_valid); end
    digit_in = 4'd1; tick();
    digit_in = 4'd15; clear = 1'b1; tick();
    digit_valid = 1'b0; enter = 1'b0; clear = 1'b0;
    n_checks++; if (result !== 7'd38 || result_valid !== 1'b1) begin n_fail++; $display("FAIL dwe_hold: got %0d/%b want 38/1", result, result_valid); end
    n_checks++; if (bad_digit !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL dwe_flags: got bad=%b ovf=%b want 0/0", bad_digit, overflow); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    n_checks++; if (result_valid !== 1'b0 || result !== 7'd38) begin n_fail++; $display("FAIL dwe_release: got %0d/%b want 38/0", result, result_valid); end
  endtask

  task automatic test_reset_and_clear();
    digit(4'd6); rst = 1'b1; tick(); rst = 1'b0;
    digit(4'd1); enter = 1'b1; tick(); enter = 1'b0;
    n_checks++; if (result !== 7'd1) begin n_fail++; $display("FAIL rst_mid_result: got %0d want 1", result); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (result !== 7'd0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got %0d/%b want 0/0", result, result_valid); end
    digit(4'd7); clear = 1'b1; tick(); clear = 1'b0;
    enter = 1'b1; tick(); enter = 1'b0;
    n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL clear_enter: got %b want 0", result_valid); end
    digit(4'd9); digit(4'd9); digit(4'd9);
    clear = 1'b1; digit_valid = 1'b1; digit_in = 4'd4; enter = 1'b1; tick(); quiet();
    n_checks++; if (overflow !== 1'b0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL clear_prio: got ovf=%b rv=%b want 0/0", overflow, result_valid); end
    digit(4'd2); enter = 1'b1; tick(); enter = 1'b0;
    n_checks++; if (result !== 7'd2) begin n_fail++; $display("FAIL clear_fresh: got %0d want 2", result); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
  endtask

`ifdef DIGIT_ECHO_EN
  task automatic test_echo();
    rst = 1'b1; tick(); rst = 1'b0;
    n_checks++; if (seg_echo !== 7'b1111111) begin n_fail++; $display("FAIL echo_reset: got %b want 1111111", seg_echo); end
    digit(4'd0);
    n_checks++; if (seg_echo !== 7'b0000001) begin n_fail++; $display("FAIL echo_zero: got %b want 0000001", seg_echo); end
    digit(4'd4);
    n_checks++; if (seg_echo !== 7'b1001100) begin n_fail++; $display("FAIL echo_four: got %b want 1001100", seg_echo); end
    clear = 1'b1; tick(); clear = 1'b0;
    n_checks++; if (seg_echo !== 7'b1111111) begin n_fail++; $display("FAIL echo_clear: got %b want 1111111", seg_echo); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_42();
    test_overflow();
    test_bad_digit();
    test_digit_with_enter();
    test_reset_and_clear();
`ifdef DIGIT_ECHO_EN
    test_echo();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
